// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass, load-use bubble insertion,
// and external stall/flush handling.
module id_ex_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               id_valid,
  input  logic [XLEN-1:0]    id_pc,
  input  logic [XLEN-1:0]    id_imm,
  input  logic [4:0]         id_rs1,
  input  logic [4:0]         id_rs2,
  input  logic [4:0]         id_rd,
  input  logic               id_reg_wr,
  input  logic               id_mem_rd,
  input  logic               id_mem_wr,
  input  logic               id_alu_src,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic [1:0]         id_wb_sel,
  input  logic [XLEN-1:0]    rf_rdata1,
  input  logic [XLEN-1:0]    rf_rdata2,
  input  logic               wb_reg_wr,
  input  logic [4:0]         wb_waddr,
  input  logic [XLEN-1:0]    wb_wdata,
  output logic               ex_valid,
  output logic [XLEN-1:0]    ex_pc,
  output logic [XLEN-1:0]    ex_imm,
  output logic [XLEN-1:0]    ex_op1,
  output logic [XLEN-1:0]    ex_op2,
  output logic [4:0]         ex_rs1,
  output logic [4:0]         ex_rs2,
  output logic [4:0]         ex_rd,
  output logic               ex_reg_wr,
  output logic               ex_mem_rd,
  output logic               ex_mem_wr,
  output logic               ex_alu_src,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic [1:0]         ex_wb_sel,
  output logic               load_use_hold
);

  localparam int unsigned REG_W = 5;

  typedef struct packed {
    logic               valid;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    imm;
    logic [XLEN-1:0]    op1;
    logic [XLEN-1:0]    op2;
    logic [REG_W-1:0]   rs1;
    logic [REG_W-1:0]   rs2;
    logic [REG_W-1:0]   rd;
    logic               reg_wr;
    logic               mem_rd;
    logic               mem_wr;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic [1:0]         wb_sel;
  } ex_t;

  ex_t             ex_q;
  ex_t             ex_d;
  logic [XLEN-1:0] op1_byp;
  logic [XLEN-1:0] op2_byp;

  // Operand select: x0 reads zero, a same-edge write-back wins over the stale RF read
  always_comb begin
    op1_byp = rf_rdata1;
    op2_byp = rf_rdata2;
    if (id_rs1 == '0) begin
      op1_byp = '0;
    end else if (wb_reg_wr && (wb_waddr == id_rs1)) begin
      op1_byp = wb_wdata;
    end
    if (id_rs2 == '0) begin
      op2_byp = '0;
    end else if (wb_reg_wr && (wb_waddr == id_rs2)) begin
      op2_byp = wb_wdata;
    end
  end

  // Load in EX whose destination is read by the decode instruction; a flush kills it anyway
  assign load_use_hold = ex_q.valid && ex_q.mem_rd && (ex_q.rd != '0) && id_valid &&
                         ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2)) && !flush;

  // Next contents: flush bubble > stall hold > load-use bubble > load
  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (!stall) begin
      if (load_use_hold) begin
        ex_d = '0;
      end else begin
        ex_d.valid   = id_valid;
        ex_d.pc      = id_pc;
        ex_d.imm     = id_imm;
        ex_d.op1     = op1_byp;
        ex_d.op2     = op2_byp;
        ex_d.rs1     = id_rs1;
        ex_d.rs2     = id_rs2;
        ex_d.rd      = id_rd;
        ex_d.reg_wr  = id_reg_wr  & id_valid;
        ex_d.mem_rd  = id_mem_rd  & id_valid;
        ex_d.mem_wr  = id_mem_wr  & id_valid;
        ex_d.alu_src = id_alu_src & id_valid;
        ex_d.alu_op  = id_alu_op;
        ex_d.wb_sel  = id_wb_sel;
      end
    end
  end

  // Stage register, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign ex_valid   = ex_q.valid;
  assign ex_pc      = ex_q.pc;
  assign ex_imm     = ex_q.imm;
  assign ex_op1     = ex_q.op1;
  assign ex_op2     = ex_q.op2;
  assign ex_rs1     = ex_q.rs1;
  assign ex_rs2     = ex_q.rs2;
  assign ex_rd      = ex_q.rd;
  assign ex_reg_wr  = ex_q.reg_wr;
  assign ex_mem_rd  = ex_q.mem_rd;
  assign ex_mem_wr  = ex_q.mem_wr;
  assign ex_alu_src = ex_q.alu_src;
  assign ex_alu_op  = ex_q.alu_op;
  assign ex_wb_sel  = ex_q.wb_sel;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vectors, a reference model of the stage
// contents checked every cycle, plus literal spot checks.
`timescale 1ns/1ps
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_wr;
    logic        mem_rd;
    logic        mem_wr;
    logic        alu_src;
    logic [3:0]  alu_op;
    logic [1:0]  wb_sel;
  } ex_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, id_valid;
  logic [31:0] id_pc, id_imm, rf_rdata1, rf_rdata2, wb_wdata;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_waddr;
  logic        id_reg_wr, id_mem_rd, id_mem_wr, id_alu_src, wb_reg_wr;
  logic [3:0]  id_alu_op;
  logic [1:0]  id_wb_sel;
  logic        ex_valid, ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_alu_src, load_use_hold;
  logic [31:0] ex_pc, ex_imm, ex_op1, ex_op2;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_alu_op;
  logic [1:0]  ex_wb_sel;

  int total = 0;
  int bad   = 0;
  ex_t m = '0;

  id_ex_stage #(.XLEN(32), .ALUOP_W(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_reg_wr(id_reg_wr), .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr),
    .id_alu_src(id_alu_src), .id_alu_op(id_alu_op), .id_wb_sel(id_wb_sel),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_reg_wr(wb_reg_wr), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_reg_wr(ex_reg_wr), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .ex_wb_sel(ex_wb_sel),
    .load_use_hold(load_use_hold)
  );

  always #5 clk = ~clk;

  // Operand value the execute stage must see for a source register
  function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 5'd0) return 32'd0;
    if (wb_reg_wr && wb_waddr == rs) return wb_wdata;
    return rf;
  endfunction

  // Decode must freeze when a load in EX feeds it, unless redirected
  function automatic logic model_hold();
    return m.valid && m.mem_rd && m.rd != 5'd0 && id_valid &&
           (m.rd == id_rs1 || m.rd == id_rs2) && !flush;
  endfunction

  // Reference model of the stage contents after one clock
  function automatic ex_t model_next();
    ex_t n;
    if (flush) return '0;
    if (stall) return m;
    if (model_hold()) return '0;
    n.valid   = id_valid;
    n.pc      = id_pc;
    n.imm     = id_imm;
    n.op1     = operand(id_rs1, rf_rdata1);
    n.op2     = operand(id_rs2, rf_rdata2);
    n.rs1     = id_rs1;
    n.rs2     = id_rs2;
    n.rd      = id_rd;
    n.reg_wr  = id_valid ? id_reg_wr  : 1'b0;
    n.mem_rd  = id_valid ? id_mem_rd  : 1'b0;
    n.mem_wr  = id_valid ? id_mem_wr  : 1'b0;
    n.alu_src = id_valid ? id_alu_src : 1'b0;
    n.alu_op  = id_alu_op;
    n.wb_sel  = id_wb_sel;
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m = '0;
    else        m = model_next();
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-stage comparison against the model, mid-cycle
  always @(negedge clk) begin
    ex_t act;
    act = {ex_valid, ex_pc, ex_imm, ex_op1, ex_op2, ex_rs1, ex_rs2, ex_rd,
           ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_alu_src, ex_alu_op, ex_wb_sel};
    total++;
    if (act !== m) begin
      bad++;
      $display("FAIL model_stage: got %h expected %h at %0t", act, m, $time);
    end
    total++;
    if (load_use_hold !== model_hold()) begin
      bad++;
      $display("FAIL model_hold: got %b expected %b at %0t", load_use_hold, model_hold(), $time);
    end
  end

  task automatic set_id(input logic v, input logic [31:0] pc,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic mw, input logic as,
                        input logic [3:0] op, input logic [1:0] wbs);
    id_valid = v;   id_pc = pc;   id_imm = pc ^ 32'h5A5A_0000;
    id_rs1 = rs1;   id_rs2 = rs2; id_rd = rd;
    id_reg_wr = rw; id_mem_rd = mr; id_mem_wr = mw; id_alu_src = as;
    id_alu_op = op; id_wb_sel = wbs;
    rf_rdata1 = 32'h1000_0000 | 32'(rs1);
    rf_rdata2 = 32'h2000_0000 | 32'(rs2);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    stall = 0; flush = 0; wb_reg_wr = 0; wb_waddr = 0; wb_wdata = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) tick();
    chk("reset_valid", 32'(ex_valid), 0);
    chk("reset_pc", ex_pc, 0);
    chk("reset_hold", 32'(load_use_hold), 0);
    reset = 1'b1;

    // back-to-back independent instructions
    for (int i = 0; i < 4; i++) begin
      set_id(1, 32'h100 + 32'(i * 4), 5'(i + 1), 5'(i + 2), 5'(i + 10),
             1, 0, 0, 1'(i), 4'(i + 1), 2'd0);
      tick();
      chk("b2b_pc", ex_pc, 32'h100 + 32'(i * 4));
      chk("b2b_valid", 32'(ex_valid), 1);
    end

    // write-back bypass
    set_id(1, 32'h200, 5, 6, 11, 1, 0, 0, 0, 4'd2, 2'd0);
    rf_rdata1 = 32'h11; wb_reg_wr = 1; wb_waddr = 5; wb_wdata = 32'hDEAD_BEEF;
    tick();
    chk("byp_op1", ex_op1, 32'hDEAD_BEEF);
    chk("byp_op2_rf", ex_op2, 32'h2000_0006);
    set_id(1, 32'h204, 0, 6, 11, 1, 0, 0, 0, 4'd2, 2'd0);
    rf_rdata1 = 32'h22; wb_waddr = 0;
    tick();
    chk("byp_x0_op1", ex_op1, 0);
    set_id(1, 32'h208, 5, 6, 11, 1, 0, 0, 0, 4'd2, 2'd0);
    wb_reg_wr = 0; wb_waddr = 6;
    tick();
    chk("byp_nowr_op2", ex_op2, 32'h2000_0006);
    wb_waddr = 0;

    // load-use: one bubble, then the dependent add
    set_id(1, 32'h300, 2, 3, 7, 1, 1, 0, 1, 4'd0, 2'd1);
    tick();
    chk("lu_lw_memrd", 32'(ex_mem_rd), 1);
    set_id(1, 32'h304, 1, 7, 8, 1, 0, 0, 0, 4'd3, 2'd0);
    #1 chk("lu_hold", 32'(load_use_hold), 1);
    tick();
    chk("lu_bubble", 32'(ex_valid), 0);
    chk("lu_release", 32'(load_use_hold), 0);
    tick();
    chk("lu_add_valid", 32'(ex_valid), 1);
    chk("lu_add_rs2", 32'(ex_rs2), 7);
    chk("lu_add_pc", ex_pc, 32'h304);

    // flush beats load-use
    set_id(1, 32'h310, 2, 3, 7, 1, 1, 0, 1, 4'd0, 2'd1);
    tick();
    set_id(1, 32'h314, 7, 3, 8, 1, 0, 0, 0, 4'd3, 2'd0);
    flush = 1;
    #1 chk("fl_hold", 32'(load_use_hold), 0);
    tick();
    chk("fl_valid", 32'(ex_valid), 0);
    chk("fl_regwr", 32'(ex_reg_wr), 0);
    flush = 0;
    tick();
    chk("fl_next_pc", ex_pc, 32'h314);

    // stall together with load-use: contents held, hold stays up
    set_id(1, 32'h320, 2, 3, 9, 1, 1, 0, 1, 4'd0, 2'd1);
    tick();
    set_id(1, 32'h324, 9, 4, 10, 1, 0, 0, 0, 4'd3, 2'd0);
    stall = 1;
    #1 chk("sl_hold", 32'(load_use_hold), 1);
    tick();
    chk("sl_pc_held", ex_pc, 32'h320);
    chk("sl_memrd_held", 32'(ex_mem_rd), 1);
    chk("sl_hold_kept", 32'(load_use_hold), 1);
    stall = 0;
    tick();
    chk("sl_bubble", 32'(ex_valid), 0);
    tick();
    chk("sl_add_pc", ex_pc, 32'h324);

    // stall three cycles with changing decode
    set_id(1, 32'h400, 1, 2, 3, 1, 0, 0, 0, 4'd5, 2'd0);
    tick();
    chk("st_pc", ex_pc, 32'h400);
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      set_id(1, 32'h404 + 32'(k * 4), 5'(k + 4), 5'(k + 5), 5'(k + 6), 0, 1, 1, 1, 4'(k), 2'd2);
      tick();
      chk("st_pc_held", ex_pc, 32'h400);
      chk("st_aluop_held", 32'(ex_alu_op), 5);
    end
    stall = 0;
    set_id(1, 32'h410, 1, 2, 3, 1, 0, 0, 0, 4'd6, 2'd0);
    tick();
    chk("st_release_pc", ex_pc, 32'h410);

    // invalid decode: control bits forced low
    set_id(0, 32'h500, 7, 8, 9, 1, 1, 1, 1, 4'd0, 2'd0);
    tick();
    chk("inv_valid", 32'(ex_valid), 0);
    chk("inv_regwr", 32'(ex_reg_wr), 0);
    chk("inv_memrd", 32'(ex_mem_rd), 0);
    chk("inv_memwr", 32'(ex_mem_wr), 0);
    chk("inv_alusrc", 32'(ex_alu_src), 0);
    chk("inv_pc", ex_pc, 32'h500);

    // asynchronous reset mid-stream
    set_id(1, 32'h600, 1, 2, 5, 1, 1, 0, 1, 4'd0, 2'd1);
    tick();
    chk("rst_pre_valid", 32'(ex_valid), 1);
    set_id(1, 32'h604, 5, 2, 6, 1, 0, 0, 0, 4'd3, 2'd0);
    #1 chk("rst_pre_hold", 32'(load_use_hold), 1);
    reset = 0;
    #1;
    chk("rst_async_valid", 32'(ex_valid), 0);
    chk("rst_async_pc", ex_pc, 0);
    chk("rst_async_memrd", 32'(ex_mem_rd), 0);
    chk("rst_async_hold", 32'(load_use_hold), 0);
    #3 reset = 1;
    tick();
    chk("rst_after_pc", ex_pc, 32'h604);
    chk("rst_after_valid", 32'(ex_valid), 1);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register for the simple five-stage pipeline. It sits directly downstream of the register file. It captures the two read operands, the decoded control fields and the PC/immediate, and presents them to the execute stage one cycle later. It also:
- supplies write-back-to-decode bypass, covering the case where the register file is written at the same edge its combinational read is sampled;
- detects load-use hazards and inserts a bubble;
- honours external stall and flush.

## Interface
Parameters:
- XLEN, 32, datapath width
- ALUOP_W, 4, width of ALU operation code

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hold all stage contents (downstream back-pressure)
- flush  in  1  kill the instruction entering EX (branch/jump redirect)
- id_valid  in  1  decode stage holds a real instruction
- id_pc  in  XLEN  PC of decode instruction
- id_imm  in  XLEN  sign-extended immediate
- id_rs1, id_rs2, id_rd  in  5  source and destination register indices
- id_reg_wr, id_mem_rd, id_mem_wr, id_alu_src  in  1  decoded control bits
- id_alu_op  in  ALUOP_W  ALU operation
- id_wb_sel  in  2  write-back source select
- rf_rdata1, rf_rdata2  in  XLEN  register file read data for id_rs1/id_rs2
- wb_reg_wr  in  1  write-back stage writes register file this cycle
- wb_waddr  in  5  write-back destination
- wb_wdata  in  XLEN  write-back data
- ex_valid  out  1  EX holds a real instruction
- ex_pc, ex_imm, ex_op1, ex_op2  out  XLEN  registered PC, immediate, operands
- ex_rs1, ex_rs2, ex_rd  out  5  registered indices (for EX forwarding unit)
- ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_alu_src  out  1  registered control
- ex_alu_op  out  ALUOP_W  registered ALU op
- ex_wb_sel  out  2  registered write-back select
- load_use_hold  out  1  combinational; freeze PC and IF/ID register this cycle

## Operation
- Bypass, per operand, combinational:
  - op1 = wb_wdata if wb_reg_wr && wb_waddr != 0 && wb_waddr == id_rs1;
  - op1 = 0 if id_rs1 == 0;
  - otherwise op1 = rf_rdata1.
  - op2 is identical using id_rs2.
- Load-use detect: load_use_hold = ex_valid && ex_mem_rd && ex_rd != 0 && id_valid && (ex_rd == id_rs1 || ex_rd == id_rs2) && !flush.
- Register update priority at each rising edge, highest first:
  1. flush: insert bubble.
  2. stall: hold every output register unchanged.
  3. load_use_hold: insert bubble.
  4. else: load all id_* fields plus bypassed op1/op2; ex_valid <= id_valid.
- Bubble definition: ex_valid, ex_reg_wr, ex_mem_rd and ex_mem_wr go to 0; the remaining fields are don't-care but are cleared to 0.
- Invalid input: when id_valid = 0, the control bits are still loaded but are forced to 0 (no architectural side effects).
- stall with load_use_hold both high: contents held; load_use_hold stays asserted, so upstream also stays frozen.
- flush with load_use_hold both high: flush wins and load_use_hold is forced to 0.

## Timing
- Reset (reset = 0, asynchronous): every output register is cleared to 0, including ex_valid = 0 and all control bits = 0. load_use_hold therefore evaluates to 0. Reset asserted mid-operation discards the in-flight instruction immediately, without waiting for a clock edge.
- Latency: one cycle from id_* to ex_*.
- Bypass and hazard detect are same-cycle combinational, with no added latency.
- A load-use costs exactly one bubble cycle. On the following cycle ex_mem_rd is 0 from the bubble, so the hold releases automatically.
- Throughput: one instruction per cycle when there is no stall, flush or hazard.

## Test plan
- Reset: drive reset = 0 mid-stream with ex_valid = 1 -> all outputs read 0 before the next edge; after release, the first edge loads id_* normally.
- Bypass: id_rs1 = 5, rf_rdata1 = 0x11, wb_reg_wr = 1, wb_waddr = 5, wb_wdata = 0xDEADBEEF -> next cycle ex_op1 = 0xDEADBEEF. Repeat with wb_waddr = 0 and id_rs1 = 0 -> ex_op1 = 0.
- Load-use: EX holds lw with ex_rd = 7, decode has add with id_rs2 = 7 -> load_use_hold = 1 for one cycle; next edge ex_valid = 0; the following edge loads the add with ex_rs2 = 7.
- Flush priority: flush = 1 together with a load-use condition -> load_use_hold = 0; next edge ex_valid = 0, ex_reg_wr = 0.
- Stall: stall = 1 for 3 cycles with changing id_* -> all ex_* outputs are constant; on release, the next edge loads the current id_*.
- Back-to-back: 4 valid independent instructions with no hazards -> each appears on ex_* exactly one cycle after it was on id_*, with no gaps.
